// File: rtl/loader_sdram_bridge.sv
// Loader-to-SDRAM bridge: queues loader bytes in a small FIFO and replays them
// as SDRAM writes, one per NES clock-enable slot.
module loader_sdram_bridge #(
  parameter int         ADDR_W     = 22,
  parameter int         DATA_W     = 8,
  parameter int         FIFO_LOG2  = 3,
  parameter logic [1:0] SLOT_PHASE = 2'd3
) (
  input  logic                 clock,
  input  logic                 R_reset,
  input  logic [1:0]           i_nes_ce,
  input  logic                 i_wr,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_data,
  input  logic                 i_load_done,
  output logic                 o_mem_we,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [DATA_W-1:0]    o_mem_data,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic [FIFO_LOG2:0]   o_level
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]    fifo_addr_q [DEPTH];
  logic [DATA_W-1:0]    fifo_data_q [DEPTH];

  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   level_q, level_d;

  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_data_q, mem_data_d;
  logic                 overflow_q, overflow_d;

  logic slot;
  logic empty;
  logic full;
  logic pop;
  logic push_req;
  logic push;

  // Level never exceeds DEPTH, so its top bit alone flags a full FIFO.
  assign slot     = (i_nes_ce == SLOT_PHASE);
  assign empty    = (level_q == '0);
  assign full     = level_q[FIFO_LOG2];
  assign pop      = slot & ~empty;
  assign push_req = i_wr & ~i_load_done;
  assign push     = push_req & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (push_req & ~push);

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    if (slot) begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            mem_addr_d = fifo_addr_q[rd_ptr_q];
            mem_data_d = fifo_data_q[rd_ptr_q];
            mem_we_d   = 1'b1;
            state_d    = S_WRITE;
          end
        end
        S_WRITE: begin
          if (pop) begin
            mem_addr_d = fifo_addr_q[rd_ptr_q];
            mem_data_d = fifo_data_q[rd_ptr_q];
            mem_we_d   = 1'b1;
          end else begin
            mem_we_d   = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: begin
          mem_we_d = 1'b0;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_addr;
      fifo_data_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (R_reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_busy     = ~empty | mem_we_q;
  assign o_overflow = overflow_q;
  assign o_level    = level_q;

endmodule
